// File: rtl/sdram_block_responder.sv
// rtl/sdram_block_responder.sv - memory-side responder for cache block transfers
// Word strobes hit a behavioural array; reads return after RD_LAT cycles, blocks of 16 words are tracked.
module sdram_block_responder #(
  parameter int DATA_W     = 8,
  parameter int BLK_ADDR_W = 6,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_strb,
  input  logic                  mem_wr_rd,
  input  logic [BLK_ADDR_W-1:0] mem_addr,
  input  logic [3:0]            mem_offset,
  input  logic [DATA_W-1:0]     mem_din,
  output logic [DATA_W-1:0]     mem_dout,
  output logic                  mem_dvalid,
  output logic                  mem_busy,
  output logic                  block_done,
  output logic                  seq_err,
  output logic [7:0]            blk_cnt
);

  localparam int AW    = BLK_ADDR_W + 4;
  localparam int DEPTH = 1 << AW;
  // RD_WAIT lasts RD_LAT-1 cycles, so the countdown starts at RD_LAT-2.
  localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              seq_err_q, seq_err_d;
  logic [7:0]        blk_cnt_q, blk_cnt_d;
  logic [3:0]        exp_off_q, exp_off_d;
  logic              dir_q, dir_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic          accept;
  logic          drop;
  logic          mem_we;
  logic          err;
  logic [AW-1:0] word_addr;

  assign word_addr = {mem_addr, mem_offset};
  assign accept    = mem_strb && (state_q != RD_WAIT);
  assign drop      = mem_strb && (state_q == RD_WAIT);
  assign mem_we    = accept && mem_wr_rd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rd_last_d = rd_last_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    exp_off_d = exp_off_q;
    dir_d     = dir_q;
    err       = drop;

    case (state_q)
      IDLE, RD_RESP: begin
        state_d = IDLE;
        if (accept && mem_wr_rd) begin
          done_d = (mem_offset == 4'd15);
        end else if (accept) begin
          rd_addr_d = word_addr;
          rd_last_d = (mem_offset == 4'd15);
          if (RD_LAT == 1) begin
            state_d = RD_RESP;
            dout_d  = mem_q[word_addr];
            done_d  = (mem_offset == 4'd15);
          end else begin
            state_d = RD_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RD_RESP;
          dout_d  = mem_q[rd_addr_q];
          done_d  = rd_last_q;
        end else begin
          cnt_d = 3'(cnt_q - 3'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Block sequencing: offset order and direction consistency within a block.
    if (accept) begin
      exp_off_d = exp_off_q + 4'd1;
      if (mem_offset != exp_off_q) err = 1'b1;
      if (mem_offset == 4'd0) dir_d = mem_wr_rd;
      else if (mem_wr_rd != dir_q) err = 1'b1;
    end

    seq_err_d = seq_err_q | err;
    blk_cnt_d = blk_cnt_q + 8'(done_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      seq_err_q <= 1'b0;
      blk_cnt_q <= 8'd0;
      exp_off_q <= 4'd0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_last_q <= rd_last_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      seq_err_q <= seq_err_d;
      blk_cnt_q <= blk_cnt_d;
      exp_off_q <= exp_off_d;
      dir_q     <= dir_d;
    end
  end

  // The array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_addr] <= mem_din;
  end

  assign mem_dout   = dout_q;
  assign mem_dvalid = (state_q == RD_RESP);
  assign mem_busy   = (state_q == RD_WAIT);
  assign block_done = done_q;
  assign seq_err    = seq_err_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_sdram_block_responder.sv
// tb/tb_sdram_block_responder.sv - directed bench for sdram_block_responder
// Three instances share inputs (RD_LAT 2, 3, 1); each phase checks only the relevant one.
module tb_sdram_block_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_strb = 1'b0;
  logic       mem_wr_rd = 1'b0;
  logic [5:0] mem_addr = '0;
  logic [3:0] mem_offset = '0;
  logic [7:0] mem_din = '0;

  logic [7:0] dout2, dout3, dout1, cnt2, cnt3, cnt1;
  logic       dv2, dv3, dv1, busy2, busy3, busy1, done2, done3, done1, err2, err3, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_block_responder #(.DATA_W(8), .BLK_ADDR_W(6), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_strb(mem_strb), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_offset(mem_offset), .mem_din(mem_din), .mem_dout(dout2), .mem_dvalid(dv2),
    .mem_busy(busy2), .block_done(done2), .seq_err(err2), .blk_cnt(cnt2));

  sdram_block_responder #(.DATA_W(8), .BLK_ADDR_W(6), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_strb(mem_strb), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_offset(mem_offset), .mem_din(mem_din), .mem_dout(dout3), .mem_dvalid(dv3),
    .mem_busy(busy3), .block_done(done3), .seq_err(err3), .blk_cnt(cnt3));

  sdram_block_responder #(.DATA_W(8), .BLK_ADDR_W(6), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_strb(mem_strb), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_offset(mem_offset), .mem_din(mem_din), .mem_dout(dout1), .mem_dvalid(dv1),
    .mem_busy(busy1), .block_done(done1), .seq_err(err1), .blk_cnt(cnt1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change at negedge; after tick we sit mid-cycle following the sampling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_strb(input logic wr, input logic [5:0] a, input logic [3:0] o, input logic [7:0] d);
    mem_strb = 1'b1; mem_wr_rd = wr; mem_addr = a; mem_offset = o; mem_din = d;
  endtask

  task automatic idle_in();
    mem_strb = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic read_word2(input logic [3:0] o, input logic [7:0] exp_d);
    set_strb(1'b0, 6'd5, o, 8'h00);
    tick();
    chk("rd2_busy", busy2, 1);
    chk("rd2_dv_early", dv2, 0);
    idle_in();
    tick();
    chk("rd2_dv", dv2, 1);
    chk("rd2_dout", dout2, exp_d);
    chk("rd2_done", done2, (o == 4'd15));
    chk("rd2_busy_off", busy2, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_dout", dout2, 0);
    chk("rst_dvalid", dv2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_err", err2, 0);
    chk("rst_cnt", cnt2, 0);
    rst = 1'b0;
    tick();

    // Write block 5, strobe every second cycle.
    for (int i = 0; i < 16; i++) begin
      set_strb(1'b1, 6'd5, 4'(i), 8'(8'h10 + i));
      tick();
      chk("wr_dv", dv2, 0);
      chk("wr_busy", busy2, 0);
      chk("wr_done", done2, (i == 15));
      chk("wr_cnt", cnt2, (i == 15) ? 1 : 0);
      idle_in();
      tick();
      chk("wr_done_gap", done2, 0);
    end
    chk("wr_blk_cnt", cnt2, 1);
    chk("wr_seq_err", err2, 0);

    // Read back; next strobe lands in the RD_RESP cycle (back-to-back acceptance).
    for (int i = 0; i < 16; i++) read_word2(4'(i), 8'(8'h10 + i));
    chk("rd_blk_cnt", cnt2, 2);
    chk("rd_seq_err", err2, 0);
    tick();
    chk("rd_done_clear", done2, 0);

    // Sequence error: offsets 0,1,3.
    pulse_reset();
    chk("seq_rst_cnt", cnt2, 0);
    set_strb(1'b1, 6'd9, 4'd0, 8'hA0); tick(); idle_in(); tick();
    set_strb(1'b1, 6'd9, 4'd1, 8'hA1); tick(); idle_in();
    chk("seq_err_before", err2, 0);
    tick();
    set_strb(1'b1, 6'd9, 4'd3, 8'hA3); tick(); idle_in();
    chk("seq_err_set", err2, 1);
    tick();
    set_strb(1'b0, 6'd9, 4'd3, 8'h00); tick(); idle_in(); tick();
    chk("seq_rd_dv", dv2, 1);
    chk("seq_rd_word3", dout2, 8'hA3);
    set_strb(1'b0, 6'd9, 4'd1, 8'h00); tick(); idle_in(); tick();
    chk("seq_rd_word1", dout2, 8'hA1);
    chk("seq_err_sticky", err2, 1);

    // Reset in the middle of a read.
    pulse_reset();
    set_strb(1'b0, 6'd5, 4'd0, 8'h00);
    tick();
    idle_in();
    chk("mid_busy", busy2, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy2, 0);
    chk("mid_rst_dv", dv2, 0);
    chk("mid_rst_dout", dout2, 0);
    chk("mid_rst_err", err2, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_dv_a", dv2, 0);
    tick();
    chk("mid_no_dv_b", dv2, 0);
    for (int i = 0; i < 16; i++) read_word2(4'(i), 8'(8'h10 + i));
    chk("mid_blk_cnt", cnt2, 1);
    chk("mid_seq_err", err2, 0);
    tick();

    // Busy drop with RD_LAT=3.
    pulse_reset();
    set_strb(1'b0, 6'd5, 4'd0, 8'h00);
    tick();
    chk("drop_busy1", busy3, 1);
    set_strb(1'b0, 6'd5, 4'd1, 8'h00);
    tick();
    idle_in();
    chk("drop_busy2", busy3, 1);
    chk("drop_dv_early", dv3, 0);
    chk("drop_err", err3, 1);
    tick();
    chk("drop_dv", dv3, 1);
    chk("drop_dout", dout3, 8'h10);
    tick();
    chk("drop_dv_once", dv3, 0);
    chk("drop_busy_idle", busy3, 0);
    tick();
    chk("drop_no_second", dv3, 0);

    // RD_LAT=1: read-after-write, never busy, dout holds.
    pulse_reset();
    set_strb(1'b1, 6'd7, 4'd0, 8'h5A);
    tick();
    chk("l1_wr_dv", dv1, 0);
    set_strb(1'b0, 6'd7, 4'd0, 8'h00);
    tick();
    idle_in();
    chk("l1_dv", dv1, 1);
    chk("l1_busy", busy1, 0);
    chk("l1_raw", dout1, 8'h5A);
    tick();
    chk("l1_dv_off", dv1, 0);
    chk("l1_hold", dout1, 8'h5A);
    set_strb(1'b0, 6'd5, 4'd2, 8'h00);
    tick();
    idle_in();
    chk("l1_old_data", dout1, 8'h12);
    chk("l1_busy2", busy1, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
